// File: rtl/pipe_pkg.sv
// pipe_pkg: shared width helper and parameter limits for pipe_credit_fifo.
package pipe_pkg;
    localparam int MIN_DEPTH = 2;
    localparam int MIN_L = 1;
    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/circ_buf.sv
// circ_buf: DEPTH x DW circular buffer with show-ahead head and occupancy count.
module circ_buf
    import pipe_pkg::*;
#(
    parameter int DW = 16,
    parameter int DEPTH = 8,
    parameter int PW = clog2w(DEPTH),
    parameter int CW = clog2w(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          rdy,
    output logic          vld,
    output logic [DW-1:0] dout,
    output logic [CW-1:0] count
);
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign vld = count != '0;
    assign dout = mem[rd_ptr];
    assign do_push = push && count != CW'(DEPTH);
    assign do_pop = vld && rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/pipe_credit_fifo.sv
// pipe_credit_fifo: credit-gated drain buffer behind a fixed-latency pipeline.
// Define PIPE_CREDIT_LATENCY_CHECK_EN to add an issue-delay shadow that flags latency mismatches.
module pipe_credit_fifo
    import pipe_pkg::*;
#(
    parameter int DW = 16,
    parameter int L = 4,
    parameter int DEPTH = 8,
    parameter int CW = clog2w(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          issue_ok,
    input  logic          in_issue,
    input  logic          in_vld,
    input  logic [DW-1:0] in_data,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] credit,
    output logic          err
);
    logic [CW-1:0] count, in_flight;
    logic [CW:0] used;
    logic dec, up, down, lat_err;

    if (DEPTH < MIN_DEPTH) begin : g_bad_depth
        $error("pipe_credit_fifo: DEPTH must be >= 2");
    end
    if (L < MIN_L) begin : g_bad_l
        $error("pipe_credit_fifo: L must be >= 1");
    end

    circ_buf #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_buf (
        .clk(clk), .rst(rst), .push(in_vld), .din(in_data),
        .rdy(out_rdy), .vld(out_vld), .dout(out_data), .count(count)
    );

    // Credits account for both buffered and still-in-pipeline results.
    assign used = {1'b0, count} + {1'b0, in_flight};
    assign issue_ok = used < (CW + 1)'(DEPTH);
    assign credit = issue_ok ? CW'((CW + 1)'(DEPTH) - used) : '0;
    assign dec = in_vld && in_flight != '0;
    assign up = in_issue && !dec && in_flight != CW'(DEPTH);
    assign down = dec && !in_issue;

`ifdef PIPE_CREDIT_LATENCY_CHECK_EN
    logic [L-1:0] sr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr <= '0;
        else sr <= (sr << 1) | L'(in_issue);
    end
    assign lat_err = sr[L-1] != in_vld;
`else
    assign lat_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_flight <= '0;
            err <= 1'b0;
        end else begin
            in_flight <= in_flight + CW'(up) - CW'(down);
            err <= err | (in_vld && count == CW'(DEPTH)) | (in_issue && !issue_ok)
                 | (in_vld && in_flight == '0) | lat_err;
        end
    end
endmodule

// File: doc/pipe_credit_fifo.md
Name: pipe_credit_fifo

Overview:
- Credit-based drain buffer that sits directly downstream of a fixed-latency, non-stallable delay pipeline (latency L, no backpressure).
- Grants issue permission upstream only when buffer space is guaranteed for every result still in flight.
- Absorbs results arriving exactly L cycles after issue and re-emits them as a valid/ready stream.
- Lets non-stallable compute pipelines feed backpressured consumers without data loss.

Parameters:
- DW, 16, data width of pipeline results.
- L, 4, pipeline latency in cycles from in_issue to in_vld; must be >= 1.
- DEPTH, 8, buffer entries; must be >= 2. Full throughput requires DEPTH >= L+2. Non-power-of-2 is allowed.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_ok  out  1  upstream may assert in_issue this cycle.
- in_issue  in  1  upstream launched one item into the pipeline this cycle; legal only when issue_ok=1.
- in_vld  in  1  pipeline result valid (L cycles after the matching in_issue).
- in_data  in  DW  pipeline result.
- out_vld  out  1  head entry valid.
- out_rdy  in  1  consumer accepts head entry.
- out_data  out  DW  head entry data (show-ahead).
- credit  out  CW  free credits = DEPTH - count - in_flight; CW = clog2(DEPTH+1).
- err  out  1  sticky protocol error.

Behaviour:
- Reset values (rst=0, asynchronous): count=0, in_flight=0, rd_ptr=wr_ptr=0, out_vld=0, err=0. Consequently issue_ok=1 and credit=DEPTH. out_data content is don't-care.
- Storage is a circular buffer. wr_ptr and rd_ptr wrap from DEPTH-1 to 0.
- Push: on in_vld=1 and count<DEPTH, write mem[wr_ptr] and advance wr_ptr.
- Pop: on out_vld & out_rdy, advance rd_ptr.
- count update: +push -pop. Simultaneous push and pop leaves count unchanged.
- out_vld = (count != 0). out_data = mem[rd_ptr]. Data written at edge t is visible at out_data in cycle t+1 (latency 1 from in_vld to out_vld).
- in_flight update: +in_issue -in_vld. Simultaneous issue and arrival leaves in_flight unchanged.
- issue_ok = (count + in_flight) < DEPTH. Computed from registers only; there is no combinational path from out_rdy or in_issue.
- A pop in cycle t frees a credit visible in cycle t+1.
- Overflow (in_vld with count==DEPTH): data dropped, err set.
- Illegal issue (in_issue while issue_ok=0): still counted into in_flight (saturating at DEPTH), err set.
- Underflow (in_vld while in_flight==0): push still performed if space, in_flight held at 0, err set.
- err clears only on reset.
- Mid-operation reset clears all state immediately. The upstream pipeline must share the same reset; results arriving after reset from pre-reset issues raise err.
- Counters are CW bits wide and never wrap.

Optional Feature:
- Macro: PIPE_CREDIT_LATENCY_CHECK_EN.
- Defined:
  - an internal L-stage, 1-bit shift register (reset to 0) delays in_issue;
  - any cycle where delayed issue != in_vld sets err, catching latency mismatch or a lost result.
- Undefined: no shadow register; err reflects only the overflow, illegal-issue and underflow conditions.

Decomposition:
- Package pipe_pkg holds:
  - a clog2-based width function for CW and pointer widths;
  - the DEPTH >= 2 and L >= 1 parameter-check constants/assertion macros.
- Natural sub-module: circ_buf, the DEPTH x DW circular storage with pointers, count, and push/pop.
- pipe_credit_fifo itself contains the credit/in_flight logic, the error logic and the optional latency checker.

Test Plan:
- Reset defaults: defaults L=4, DEPTH=8, hold rst low -> issue_ok=1, credit=8, out_vld=0, err=0.
- Full rate: issue every cycle with in_vld driven 4 cycles later, out_rdy=1, 100 items -> issue_ok never drops, data 0..99 in order, err=0.
- Backpressure: out_rdy=0, issue whenever issue_ok -> exactly 8 issues accepted, credit reaches 0, 8 entries held. Then out_rdy=1 for 1 cycle -> credit=1 the next cycle.
- Simultaneous events: count=3 and in_flight=2, with in_vld, in_issue and pop in the same cycle -> count stays 3, in_flight stays 2, credit stays 3.
- Protocol errors:
  - inject in_vld with in_flight=0 -> err=1 next cycle and stays 1;
  - force in_issue with issue_ok=0 -> err=1.
- Latency check (macro defined): deliver a result 5 cycles after issue instead of 4 -> err=1. With the macro undefined, the same stimulus gives err=0 (no overflow).
- Mid-stream reset: assert rst with 5 entries buffered -> out_vld=0 and credit=8 asynchronously, before the next clk edge.
